// File: rtl/sequenciador_decodificador_if.sv
// sequenciador_decodificador_if: character input, decoder drive and verdict handshake bundle
interface sequenciador_decodificador_if;
  logic [6:0] Car_in;
  logic       Car_last;
  logic       Car_valid;
  logic       Car_ready;
  logic [6:0] Dec_Entrada;
  logic       Dec_Controle;
  logic       Dec_Reset;
  logic [3:0] Dec_Saida;
  logic [3:0] Resultado;
  logic       Resultado_valid;
  logic       Resultado_ready;
  logic [7:0] Cont_aceitas;
  modport master (
    output Car_in, Car_last, Car_valid, Dec_Saida, Resultado_ready,
    input  Car_ready, Dec_Entrada, Dec_Controle, Dec_Reset, Resultado, Resultado_valid, Cont_aceitas
  );
  modport slave (
    input  Car_in, Car_last, Car_valid, Dec_Saida, Resultado_ready,
    output Car_ready, Dec_Entrada, Dec_Controle, Dec_Reset, Resultado, Resultado_valid, Cont_aceitas
  );
endinterface

// File: rtl/sequenciador_decodificador.sv
// sequenciador_decodificador: buffers characters and sequences them through one decoder, one verdict per word
module sequenciador_decodificador #(
  parameter int PROF = 8,
  parameter int LAT = 1,
  parameter int RST_CYC = 2,
  parameter logic [3:0] COD_S1 = 4'd6,
  parameter logic [3:0] COD_S2 = 4'd7,
  parameter logic [3:0] COD_INV = 4'd15
) (
  input logic clk,
  input logic Reset_n,
  sequenciador_decodificador_if.slave bus
);
  localparam int AW = $clog2(PROF);
  typedef enum logic [2:0] {RST_DEC, IDLE, FEED, WAIT, CHECK, IDLE_MID, FLUSH, REPORT} estado_t;
  estado_t estado, prox;
  logic [7:0] mem [PROF];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] cnt, cnt_n;
  logic [7:0] tmr, cont_r, head;
  logic [6:0] car_r;
  logic [3:0] res_r, veredito;
  logic last_r, vazio, push, pop;
  assign head = mem[rd_ptr];
  assign vazio = cnt == '0;
  assign push = bus.Car_valid && bus.Car_ready;
  assign pop = estado == FEED || (estado == FLUSH && !vazio);
  assign cnt_n = cnt + (AW+1)'(push) - (AW+1)'(pop);
  assign veredito = bus.Dec_Saida == COD_S1 ? 4'd1 :
                    bus.Dec_Saida == COD_S2 ? 4'd2 :
                    bus.Dec_Saida == COD_INV ? 4'd3 :
                    last_r ? 4'd4 : 4'd0;
  assign bus.Resultado = res_r;
  assign bus.Cont_aceitas = cont_r;
  // next state and decoder/verdict strobes decoded from the current state
  always_comb begin
    prox = estado;
    bus.Dec_Controle = estado == FEED;
    bus.Dec_Reset = estado == RST_DEC;
    bus.Dec_Entrada = estado == FEED ? head[6:0] : car_r;
    bus.Resultado_valid = estado == REPORT;
    case (estado)
      RST_DEC: prox = tmr == 8'(RST_CYC - 1) ? IDLE : RST_DEC;
      IDLE, IDLE_MID: prox = vazio ? estado : FEED;
      FEED: prox = WAIT;
      WAIT: prox = tmr == 8'(LAT - 1) ? CHECK : WAIT;
      CHECK: prox = veredito != 4'd0 ? (last_r ? REPORT : FLUSH) : (vazio ? IDLE_MID : FEED);
      FLUSH: prox = !vazio && head[7] ? REPORT : FLUSH;
      REPORT: prox = bus.Resultado_ready ? RST_DEC : REPORT;
      default: prox = RST_DEC;
    endcase
  end
  // state register; tmr counts cycles spent in the current state
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      estado <= RST_DEC;
      tmr <= '0;
    end else begin
      estado <= prox;
      tmr <= estado != prox ? 8'd0 : tmr + 8'd1;
    end
  end
  // fifo pointers, occupancy and registered not-full flag
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      bus.Car_ready <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      cnt <= cnt_n;
      bus.Car_ready <= cnt_n != (AW+1)'(PROF);
    end
  end
  // fifo storage: {last, char} per entry
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.Car_last, bus.Car_in};
  end
  // held character, word-end flag, verdict and accepted-word counter
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      car_r <= '0;
      last_r <= 1'b0;
      res_r <= '0;
      cont_r <= '0;
    end else begin
      if (estado == RST_DEC) car_r <= '0;
      if (estado == FEED) begin
        car_r <= head[6:0];
        last_r <= head[7];
      end
      if (estado == CHECK && veredito != 4'd0) res_r <= veredito;
      if (estado == REPORT && bus.Resultado_ready && (res_r == 4'd1 || res_r == 4'd2)) cont_r <= cont_r + 8'd1;
    end
  end
endmodule
